// File: rtl/lc_ram_arbiter.sv
// Round-robin arbiter giving two requesters one-at-a-time access to a single-port-style
// RAM with one-cycle read latency; each transaction ends with a one-cycle ack pulse.
module lc_ram_arbiter #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] ram_raddr,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_wen,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RWAIT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state_r;
    state_t next_state_s;
    logic   start_s;
    logic   grant_b_s;
    logic   last_grant_r;   // 1 = B granted last
    logic   win_b_r;        // 1 = B owns the transaction in flight
    logic   we_r;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and arbitration decision
    always_comb begin
        next_state_s = state_r;
        start_s      = 1'b0;
        grant_b_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (a_req || b_req) begin
                    start_s      = 1'b1;
                    // on a tie, B wins only if A was granted last
                    grant_b_s    = b_req && (!a_req || !last_grant_r);
                    next_state_s = ACCESS;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCESS: begin
                if (we_r) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RWAIT;
                end
            end
            RWAIT:   next_state_s = DONE;
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Transaction latch, RAM drive, read capture and ack generation
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_r <= 1'b1;
            win_b_r      <= 1'b0;
            we_r         <= 1'b0;
            ram_raddr    <= {AW{1'b0}};
            ram_waddr    <= {AW{1'b0}};
            ram_wdata    <= {DW{1'b0}};
            ram_wen      <= 1'b0;
            a_ack        <= 1'b0;
            b_ack        <= 1'b0;
            a_rdata      <= {DW{1'b0}};
            b_rdata      <= {DW{1'b0}};
            busy         <= 1'b0;
        end else begin
            // RAM outputs are loaded on entry to ACCESS, so they line up with that cycle
            if (start_s) begin
                last_grant_r <= grant_b_s;
                win_b_r      <= grant_b_s;
                we_r         <= grant_b_s ? b_we : a_we;
                ram_raddr    <= grant_b_s ? b_addr : a_addr;
                ram_waddr    <= grant_b_s ? b_addr : a_addr;
                ram_wdata    <= grant_b_s ? b_wdata : a_wdata;
                ram_wen      <= grant_b_s ? b_we : a_we;
            end else begin
                ram_wen      <= 1'b0;
            end
            if (state_r == RWAIT) begin
                if (win_b_r) begin
                    b_rdata <= ram_rdata;
                end else begin
                    a_rdata <= ram_rdata;
                end
            end
            a_ack <= (next_state_s == DONE) && !win_b_r;
            b_ack <= (next_state_s == DONE) && win_b_r;
            busy  <= (next_state_s != IDLE);
        end
    end

endmodule

// File: tb/tb_lc_ram_arbiter.sv
// Directed bench for lc_ram_arbiter with a behavioural one-cycle-latency RAM.
module tb_lc_ram_arbiter;

    logic        clk;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [6:0]  a_addr, b_addr;
    logic [11:0] a_wdata, b_wdata;
    logic        a_ack, b_ack;
    logic [11:0] a_rdata, b_rdata;
    logic [6:0]  ram_raddr, ram_waddr;
    logic [11:0] ram_wdata, ram_rdata;
    logic        ram_wen, busy;

    int checks = 0;
    int errors = 0;

    logic [11:0] mem [0:127] = '{0: 12'h123, default: 12'h000};

    lc_ram_arbiter #(.AW(7), .DW(12)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_wen(ram_wen), .ram_rdata(ram_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic exp_a, exp_b;
        reset = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = 7'h00; a_wdata = 12'h000;
        b_req = 1'b0; b_we = 1'b0; b_addr = 7'h00; b_wdata = 12'h000;
        step(); step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_acks", 32'({a_ack, b_ack, ram_wen}), 32'd0);
        check("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
        check("rst_ram", 32'({ram_raddr, ram_waddr, ram_wdata}), 32'd0);

        // A write 0x05/0xABC, issued in the first cycle after reset
        reset = 1'b0;
        a_req = 1'b1; a_we = 1'b1; a_addr = 7'h05; a_wdata = 12'hABC;
        step();
        check("w1_wen", 32'(ram_wen), 32'd1);
        check("w1_waddr", 32'(ram_waddr), 32'h05);
        check("w1_wdata", 32'(ram_wdata), 32'hABC);
        check("w1_busy", 32'(busy), 32'd1);
        check("w1_noack", 32'(a_ack), 32'd0);
        step();
        check("w1_aack", 32'(a_ack), 32'd1);
        check("w1_back", 32'(b_ack), 32'd0);
        check("w1_wen_off", 32'(ram_wen), 32'd0);
        a_req = 1'b0;
        step();
        check("w1_ack_pulse", 32'(a_ack), 32'd0);
        check("w1_idle", 32'(busy), 32'd0);

        // B read 0x05
        b_req = 1'b1; b_we = 1'b0; b_addr = 7'h05;
        step();
        check("r1_raddr", 32'(ram_raddr), 32'h05);
        check("r1_nowen", 32'(ram_wen), 32'd0);
        step();
        check("r1_early", 32'(b_ack), 32'd0);
        step();
        check("r1_back", 32'(b_ack), 32'd1);
        check("r1_brdata", 32'(b_rdata), 32'hABC);
        check("r1_ardata", 32'(a_rdata), 32'h000);
        check("r1_aack", 32'(a_ack), 32'd0);
        b_req = 1'b0;
        step();

        // Simultaneous requests out of reset, held for four transactions
        reset = 1'b1;
        step();
        check("rst2_brdata", 32'(b_rdata), 32'd0);
        reset = 1'b0;
        a_req = 1'b1; a_we = 1'b1; a_addr = 7'h10; a_wdata = 12'h111;
        b_req = 1'b1; b_we = 1'b1; b_addr = 7'h20; b_wdata = 12'h222;
        for (int c = 1; c <= 11; c++) begin
            step();
            exp_a = (c % 3 == 2) && ((c / 3) % 2 == 0);
            exp_b = (c % 3 == 2) && ((c / 3) % 2 == 1);
            check($sformatf("rr_aack_c%0d", c), 32'(a_ack), 32'(exp_a));
            check($sformatf("rr_back_c%0d", c), 32'(b_ack), 32'(exp_b));
            if (c % 3 == 1)
                check($sformatf("rr_waddr_c%0d", c), 32'(ram_waddr),
                      ((c / 3) % 2 == 0) ? 32'h10 : 32'h20);
        end
        a_req = 1'b0; b_req = 1'b0;
        step();

        // B writes the top address, A reads it back, then reads address 0
        b_req = 1'b1; b_we = 1'b1; b_addr = 7'h7F; b_wdata = 12'hFFF;
        step();
        check("bw_waddr", 32'(ram_waddr), 32'h7F);
        step();
        check("bw_back", 32'(b_ack), 32'd1);
        b_req = 1'b0;
        step();
        a_req = 1'b1; a_we = 1'b0; a_addr = 7'h7F;
        step(); step(); step();
        check("ar7f_ack", 32'(a_ack), 32'd1);
        check("ar7f_data", 32'(a_rdata), 32'hFFF);
        a_req = 1'b0;
        step();
        a_req = 1'b1; a_we = 1'b0; a_addr = 7'h00;
        step(); step(); step();
        check("ar00_ack", 32'(a_ack), 32'd1);
        check("ar00_data", 32'(a_rdata), 32'h123);
        a_req = 1'b0;
        step();
        check("ar00_hold", 32'(a_rdata), 32'h123);

        // Reset during RWAIT of an A read
        a_req = 1'b1; a_we = 1'b0; a_addr = 7'h05;
        step(); step();
        reset = 1'b1; a_req = 1'b0;
        step();
        check("abort_aack", 32'(a_ack), 32'd0);
        check("abort_rdata", 32'(a_rdata), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        b_req = 1'b1; b_we = 1'b1; b_addr = 7'h33; b_wdata = 12'h456;
        step();
        check("post_wen", 32'(ram_wen), 32'd1);
        check("post_waddr", 32'(ram_waddr), 32'h33);
        step();
        check("post_back", 32'(b_ack), 32'd1);
        b_req = 1'b0;
        step();

        // Write request held only while reset is high never reaches the RAM
        reset = 1'b1;
        a_req = 1'b1; a_we = 1'b1; a_addr = 7'h44; a_wdata = 12'h777;
        step();
        check("rstw_wen", 32'(ram_wen), 32'd0);
        a_req = 1'b0; reset = 1'b0;
        step();
        check("rstw_wen2", 32'(ram_wen), 32'd0);
        check("rstw_busy", 32'(busy), 32'd0);

        // A pulses req for one cycle while B's read is in flight
        b_req = 1'b1; b_we = 1'b0; b_addr = 7'h7F;
        step();
        a_req = 1'b1; a_we = 1'b1; a_addr = 7'h01; a_wdata = 12'h001;
        step();
        a_req = 1'b0;
        check("pulse_wen", 32'(ram_wen), 32'd0);
        step();
        check("pulse_back", 32'(b_ack), 32'd1);
        check("pulse_brdata", 32'(b_rdata), 32'hFFF);
        check("pulse_aack", 32'(a_ack), 32'd0);
        b_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("pulse_after_c%0d", c), 32'({a_ack, ram_wen, busy}), 32'd0);
        end
        check("pulse_mem01", 32'(mem[1]), 32'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
